// File: rtl/delay_sched_pkg.sv
// Shared definitions for the round-robin delay scheduler: state width and Gray-coded state set.
package delay_sched_pkg;

    localparam int STATE_W = 2;

    // Gray order so every legal transition flips exactly one state bit.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        ARB  = 2'b01,
        RUN  = 2'b11,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/delay_sched_if.sv
// Requester-side bus of the delay scheduler: request levels and lengths in, grant/done/status out.
interface delay_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [IDX_W-1:0]         owner;

    modport master (
        output req,
        output req_len,
        input  gnt,
        input  done,
        input  busy,
        input  owner
    );

    modport slave (
        input  req,
        input  req_len,
        output gnt,
        output done,
        output busy,
        output owner
    );

endinterface

// File: rtl/delay_sched_rr_pick.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       offset;
    logic [IDX_W:0]       sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        doubled = {req, req};
        rotated = doubled[ptr +: NUM_REQ];
        offset  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = (IDX_W + 1)'(k);
            end
        end
        sum = {1'b0, ptr} + offset;
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        valid = |req;
        idx   = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one programmable delay engine among NUM_REQ requesters.
module delay_sched
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    delay_sched_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   len_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   sel_len;
    logic [CNT_W-1:0]   eff_len;
    logic [IDX_W-1:0]   ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // A zero length still occupies the engine for one cycle.
    always_comb begin
        sel_len  = bus.req_len[int'(pick_idx) * CNT_W +: CNT_W];
        eff_len  = (sel_len == '0) ? CNT_W'(1) : sel_len;
        ptr_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            run_cnt <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state   <= ARB;
                        owner   <= pick_idx;
                        len_q   <= eff_len;
                        run_cnt <= '0;
                        gnt_q   <= onehot(pick_idx);
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    gnt_q <= '0;
                    state <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (run_cnt == len_q - 1'b1) begin
                        state  <= FIN;
                        done_q <= onehot(owner);
                    end
                end
                FIN: begin
                    done_q <= '0;
                    busy_q <= 1'b0;
                    rr_ptr <= ptr_next;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    done_q <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner;

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: directed vector table, hand-written corner sequences and a randomized run against a job-timeline model.
module tb_delay_sched;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    delay_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus_if ();

    delay_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a job is a timeline of L+2 enabled edges: offset 0 grant, 1..L running, L+1 done.
    bit m_active;
    int m_pos;
    int m_len;
    int m_owner;
    int m_ptr;

    typedef struct {
        logic [NUM_REQ-1:0]       req;
        logic [NUM_REQ*CNT_W-1:0] lens;
        logic                     en;
        logic [NUM_REQ-1:0]       gnt;
        logic [NUM_REQ-1:0]       done;
        logic                     busy;
        int                       owner;
    } vec_t;

    vec_t vecs[10];

    task automatic check_val(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_len    = 0;
        m_owner  = 0;
        m_ptr    = 0;
    endtask

    task automatic model_step(input logic en_v, input logic [NUM_REQ-1:0] req_v,
                              input logic [NUM_REQ*CNT_W-1:0] lens_v);
        int l;
        if (!en_v) return;
        if (m_active) begin
            m_pos++;
            if (m_pos > m_len + 1) begin
                m_active = 1'b0;
                m_ptr    = (m_owner + 1) % NUM_REQ;
            end
        end else if (req_v != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_v[(m_ptr + k) % NUM_REQ]) begin
                    m_owner = (m_ptr + k) % NUM_REQ;
                    break;
                end
            end
            l        = int'(lens_v[m_owner*CNT_W +: CNT_W]);
            m_len    = (l == 0) ? 1 : l;
            m_pos    = 0;
            m_active = 1'b1;
        end
    endtask

    task automatic check_output(input string tag);
        int exp_gnt;
        int exp_done;
        exp_gnt  = (m_active && m_pos == 0) ? (1 << m_owner) : 0;
        exp_done = (m_active && m_pos == m_len + 1) ? (1 << m_owner) : 0;
        check_val({tag, " gnt"},   int'(bus_if.gnt),   exp_gnt);
        check_val({tag, " done"},  int'(bus_if.done),  exp_done);
        check_val({tag, " busy"},  int'(bus_if.busy),  int'(m_active));
        check_val({tag, " owner"}, int'(bus_if.owner), m_owner);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_step(en, bus_if.req, bus_if.req_len);
        @(negedge clk);
        check_output(tag);
    endtask

    task automatic apply_stimulus(input logic [NUM_REQ-1:0] req_v,
                                  input logic [NUM_REQ*CNT_W-1:0] lens_v, input logic en_v);
        bus_if.req     = req_v;
        bus_if.req_len = lens_v;
        en             = en_v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply_stimulus('0, '0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (bus_if.busy && n < bound) begin
            tick(tag);
            n++;
        end
        check_val({tag, " idle timeout"}, int'(bus_if.busy), 0);
    endtask

    int gnt_seq[$];
    int done_at[$];
    int exp_order[5] = '{1, 2, 4, 8, 1};
    logic [NUM_REQ-1:0] held_gnt, held_done;
    logic held_busy;
    int n;

    initial begin
        // Directed table: single request (len 3), then zero-length request on requester 2.
        vecs[0] = '{4'b0010, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0010, 4'b0000, 1'b1, 1};
        vecs[1] = '{4'b0000, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0000, 4'b0000, 1'b1, 1};
        vecs[2] = '{4'b0000, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0000, 4'b0000, 1'b1, 1};
        vecs[3] = '{4'b0000, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0000, 4'b0000, 1'b1, 1};
        vecs[4] = '{4'b0000, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0000, 4'b0010, 1'b1, 1};
        vecs[5] = '{4'b0000, {3'd7, 3'd6, 3'd3, 3'd5}, 1'b1, 4'b0000, 4'b0000, 1'b0, 1};
        vecs[6] = '{4'b0100, {3'd5, 3'd0, 3'd6, 3'd7}, 1'b1, 4'b0100, 4'b0000, 1'b1, 2};
        vecs[7] = '{4'b0000, {3'd5, 3'd0, 3'd6, 3'd7}, 1'b1, 4'b0000, 4'b0000, 1'b1, 2};
        vecs[8] = '{4'b0000, {3'd5, 3'd0, 3'd6, 3'd7}, 1'b1, 4'b0000, 4'b0100, 1'b1, 2};
        vecs[9] = '{4'b0000, {3'd5, 3'd0, 3'd6, 3'd7}, 1'b1, 4'b0000, 4'b0000, 1'b0, 2};

        do_reset();
        check_val("reset gnt",   int'(bus_if.gnt),   0);
        check_val("reset done",  int'(bus_if.done),  0);
        check_val("reset busy",  int'(bus_if.busy),  0);
        check_val("reset owner", int'(bus_if.owner), 0);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].req, vecs[i].lens, vecs[i].en);
            tick($sformatf("vec%0d model", i));
            check_val($sformatf("vec%0d gnt", i),   int'(bus_if.gnt),   int'(vecs[i].gnt));
            check_val($sformatf("vec%0d done", i),  int'(bus_if.done),  int'(vecs[i].done));
            check_val($sformatf("vec%0d busy", i),  int'(bus_if.busy),  int'(vecs[i].busy));
            check_val($sformatf("vec%0d owner", i), int'(bus_if.owner), vecs[i].owner);
        end

        // Fairness: all four requesting with len 1 rotate every four cycles.
        do_reset();
        apply_stimulus(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            tick("fair");
            if (bus_if.gnt != '0) gnt_seq.push_back(int'(bus_if.gnt));
            if (bus_if.done != '0) done_at.push_back(c);
        end
        check_val("fair grant count", (gnt_seq.size() >= 5) ? 1 : 0, 1);
        check_val("fair done count", (done_at.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 5 && k < gnt_seq.size(); k++)
            check_val($sformatf("fair gnt%0d", k), gnt_seq[k], exp_order[k]);
        for (int k = 1; k < 4 && k < done_at.size(); k++)
            check_val($sformatf("fair done gap%0d", k), done_at[k] - done_at[k-1], 4);

        // Stall: len 4 with en low for three cycles mid-run delays done by three.
        do_reset();
        apply_stimulus(4'b0001, {3'd1, 3'd1, 3'd1, 3'd4}, 1'b1);
        tick("stall");
        n = 1;
        bus_if.req = '0;
        tick("stall");
        tick("stall");
        n += 2;
        held_gnt  = bus_if.gnt;
        held_done = bus_if.done;
        held_busy = bus_if.busy;
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick("stall hold");
            n++;
            check_val("stall held gnt",  int'(bus_if.gnt),  int'(held_gnt));
            check_val("stall held done", int'(bus_if.done), int'(held_done));
            check_val("stall held busy", int'(bus_if.busy), int'(held_busy));
        end
        en = 1'b1;
        while (bus_if.done == '0 && n < 30) begin
            tick("stall");
            n++;
        end
        check_val("stall done cycle", n - 3, 6);
        en = 1'b0;
        tick("stall stretch");
        check_val("stall stretched done", int'(bus_if.done), 1);
        en = 1'b1;
        tick("stall");
        check_val("stall busy after fin", int'(bus_if.busy), 0);

        // Reset in the middle of a run aborts at once; first grant afterwards searches from 0.
        do_reset();
        apply_stimulus(4'b0010, {3'd1, 3'd1, 3'd5, 3'd1}, 1'b1);
        tick("rst");
        bus_if.req = '0;
        tick("rst");
        tick("rst");
        rst_n = 1'b0;
        #1;
        check_val("midrst gnt",   int'(bus_if.gnt),   0);
        check_val("midrst done",  int'(bus_if.done),  0);
        check_val("midrst busy",  int'(bus_if.busy),  0);
        check_val("midrst owner", int'(bus_if.owner), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4'b1001, {3'd2, 3'd2, 3'd2, 3'd2}, 1'b1);
        tick("rst");
        check_val("post-rst gnt", int'(bus_if.gnt), 1);
        bus_if.req = '0;
        wait_idle("rst", 20);

        // Longest length on the top requester, then pointer wrap back to requester 0.
        do_reset();
        apply_stimulus(4'b1000, {3'd7, 3'd1, 3'd1, 3'd1}, 1'b1);
        tick("wrap");
        check_val("max gnt", int'(bus_if.gnt), 8);
        bus_if.req = '0;
        n = 0;
        while (bus_if.done == '0 && n < 20) begin
            tick("wrap");
            n++;
        end
        check_val("max run cycles", n, 8);
        tick("wrap");
        apply_stimulus(4'b1001, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
        tick("wrap");
        check_val("wrap gnt", int'(bus_if.gnt), 1);
        wait_idle("wrap", 20);
        tick("wrap");
        check_val("wrap next gnt", int'(bus_if.gnt), 8);
        bus_if.req = '0;
        wait_idle("wrap", 20);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            apply_stimulus(($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom),
                           12'($urandom), ($urandom_range(0, 9) != 0));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
